axis_byte_serializer: RTL and testbench
=======================================

AXIS_BYTE_SERIALIZER -- requirements
Module: axis_byte_serializer

Interface
REQ-001 SHALL have parameter DEPTH, 4, word-buffer depth in 32-bit words (power of 2, 2..16).
REQ-002 SHALL have port clk  in  1  the single clock for all logic.
REQ-003 SHALL have port rstn  in  1  reset, synchronous and active-low.
REQ-004 SHALL have ports i_tvalid in 1, i_tready out 1, i_tdata in 32, i_tkeep in 4, i_tlast in 1: 32-bit AXI-stream slave fed by the command processor's master port.
REQ-005 SHALL have ports o_tvalid out 1, o_tready in 1, o_tdata out 8, o_tlast out 1: byte-wide AXI-stream master to the USB FIFO bridge.
REQ-006 SHALL have port level  out  $clog2(DEPTH)+1  words currently buffered, excluding the word being serialized.
REQ-007 SHALL have port busy  out  1  high while any word is buffered or being serialized.

Function
REQ-008 SHALL accept an input word when i_tvalid && i_tready, storing {tdata, tkeep, tlast} in a FIFO.
REQ-009 SHALL drive i_tready = (level < DEPTH); it does not depend combinationally on i_tvalid.
REQ-010 SHALL use a two-state machine: IDLE (no word loaded) and SHIFT (word loaded, bytes pending).
REQ-011 IDLE -> SHIFT: when the FIFO is non-empty, pop one word into the shift register; the first byte is valid on the next cycle.
REQ-012 SHALL emit lanes with tkeep set in ascending lane order (lane 0 = tdata[7:0] first); clear lanes are skipped with zero cycle cost.
REQ-013 Non-contiguous tkeep (e.g. 0101) SHALL emit lanes 0 and 2 only.
REQ-014 o_tlast SHALL be high only on the final kept byte of a word whose tlast was set.
REQ-015 o_tvalid/o_tdata/o_tlast SHALL hold stable while o_tvalid && !o_tready.
REQ-016 On acceptance of the final kept byte, SHALL pop the next FIFO word in the same cycle if one is available (no bubble); otherwise return to IDLE.
REQ-017 Sustained throughput: one byte per clock while o_tready is high and data is available.
REQ-018 A word with tkeep=0000 SHALL be popped and discarded in one cycle with no output, even when its tlast is set; the tlast is dropped.
REQ-019 A simultaneous push and pop SHALL leave level unchanged; a push when full is impossible by REQ-009.
REQ-020 Latency: a word accepted at cycle N into an empty, idle block SHALL present its first byte at N+2.

Reset
REQ-021 With rstn low at a clk edge: state=IDLE, FIFO emptied, level=0, o_tvalid=0, o_tlast=0, o_tdata=0, busy=0, i_tready=0.
REQ-022 i_tready SHALL rise on the first cycle after rstn is released.
REQ-023 Reset mid-packet SHALL discard all buffered and partially sent data; no byte SHALL be emitted after reset until a new word arrives.

Configuration
REQ-024 Macro AXIS_SER_STATS_EN SHALL, when defined, add outputs pkt_count[15:0] (increments on each emitted byte with o_tlast), byte_count[31:0] (increments on each accepted output byte), and null_count[7:0] (increments on each discarded tkeep=0000 word). All three reset to 0 and wrap modulo 2^width.
REQ-025 Without AXIS_SER_STATS_EN, these ports and counters SHALL be absent, and behaviour SHALL be otherwise identical.

Structure
REQ-026 A shared package SHALL hold the state enum (IDLE, SHIFT), the KEEP_FULL=4'b1111 and KEEP_NONE=4'b0000 constants, and a function that returns the next set lane at or above a given index.
REQ-027 The FIFO SHALL be the sub-module axis_word_fifo (37-bit wide, DEPTH entries, push/pop/level). The serializer FSM SHALL stay in the top module.

Verification
REQ-028 Single word 0x44332211, keep=1111, last=1, o_tready=1 -> bytes 11,22,33,44 on consecutive cycles, o_tlast only on 44, first byte at N+2.
REQ-029 Two back-to-back words (keep 1111, last=0 then keep 0011, last=1) -> six contiguous bytes with no bubble and o_tlast on the sixth.
REQ-030 keep=0101, data 0xDDCCBBAA, last=1 -> bytes AA then CC, o_tlast on CC.
REQ-031 o_tready held low for 20 cycles while 5 words are offered with DEPTH=4 -> i_tready low once level=4; no data lost; all 20 bytes emitted in order after release.
REQ-032 Word with keep=0000, last=1 between two normal packets -> no output byte for it, and null_count+1 when AXIS_SER_STATS_EN is defined.
REQ-033 rstn asserted after the 2nd byte of a 4-byte word -> o_tvalid=0 the next cycle, level=0, and no residual bytes after release.

Source files
------------

// File: rtl/axis_byte_serializer_pkg.sv
// Shared types, constants and lane-scan helpers for the 32-bit to 8-bit AXI-stream serializer.
package axis_byte_serializer_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned KEEP_W = 4;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned WORD_W = DATA_W + KEEP_W + 1;

  localparam logic [KEEP_W-1:0] KEEP_FULL = 4'b1111;
  localparam logic [KEEP_W-1:0] KEEP_NONE = 4'b0000;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } ser_state_e;

  typedef struct packed {
    logic              last;
    logic [KEEP_W-1:0] keep;
    logic [DATA_W-1:0] data;
  } axis_word_t;

  // Lowest set lane at or above 'from'; callers only use it on a non-empty mask.
  function automatic logic [1:0] next_lane(input logic [KEEP_W-1:0] keep,
                                           input logic [1:0]        from);
    logic [1:0] lane;
    lane = 2'd0;
    for (int i = KEEP_W - 1; i >= 0; i--) begin
      if (i >= int'(from) && keep[i]) lane = 2'(i);
    end
    return lane;
  endfunction

  function automatic logic [BYTE_W-1:0] lane_byte(input logic [DATA_W-1:0] data,
                                                  input logic [1:0]        lane);
    return data[{lane, 3'b000} +: BYTE_W];
  endfunction

endpackage

// File: rtl/axis_word_fifo.sv
// Word buffer for the serializer: DEPTH entries of {tlast, tkeep, tdata}, head readable without a pop.
module axis_word_fifo
  import axis_byte_serializer_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       push_i,
  input  logic [WORD_W-1:0]          wr_word_i,
  input  logic                       pop_i,
  output logic [WORD_W-1:0]          rd_word_c_o,
  output logic [$clog2(DEPTH):0]     level_o
);

  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned LVL_W = AW + 1;

  logic [WORD_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]  count_q, count_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q + LVL_W'(push_i) - LVL_W'(pop_i);
    if (push_i) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_i)  rd_ptr_d = rd_ptr_q + AW'(1);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only read once counted as valid.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= wr_word_i;
  end

  assign rd_word_c_o = mem_q[rd_ptr_q];
  assign level_o     = count_q;

endmodule

// File: rtl/axis_byte_serializer.sv
// 32-bit AXI-stream to byte-stream serializer with word FIFO; honours tkeep and tlast.
// Optional statistics counters are enabled by defining AXIS_SER_STATS_EN.
module axis_byte_serializer
  import axis_byte_serializer_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   i_tvalid,
  output logic                   i_tready,
  input  logic [DATA_W-1:0]      i_tdata,
  input  logic [KEEP_W-1:0]      i_tkeep,
  input  logic                   i_tlast,
  output logic                   o_tvalid,
  input  logic                   o_tready,
  output logic [BYTE_W-1:0]      o_tdata,
  output logic                   o_tlast,
  output logic [$clog2(DEPTH):0] level,
  output logic                   busy
`ifdef AXIS_SER_STATS_EN
  ,
  output logic [15:0]            pkt_count,
  output logic [31:0]            byte_count,
  output logic [7:0]             null_count
`endif
);

  localparam int unsigned LVL_W = $clog2(DEPTH) + 1;

  ser_state_e        state_q, state_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [KEEP_W-1:0] rem_q, rem_d;
  logic              last_q, last_d;
  logic              o_tvalid_q, o_tvalid_d;
  logic [BYTE_W-1:0] o_tdata_q, o_tdata_d;
  logic              o_tlast_q, o_tlast_d;
  logic              i_tready_q, i_tready_d;
  logic              busy_q, busy_d;

  logic              push, pop, load, discard, byte_acc;
  logic [1:0]        lane;
  logic [WORD_W-1:0] fifo_rd;
  logic [LVL_W-1:0]  fifo_level, lvl_nxt;
  axis_word_t        head;

  axis_word_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rstn        (rstn),
    .push_i      (push),
    .wr_word_i   ({i_tlast, i_tkeep, i_tdata}),
    .pop_i       (pop),
    .rd_word_c_o (fifo_rd),
    .level_o     (fifo_level)
  );

  assign head     = axis_word_t'(fifo_rd);
  assign push     = i_tvalid && i_tready_q;
  assign byte_acc = o_tvalid_q && o_tready;

  // Serializer next-state: rem holds kept lanes not yet presented on o_tdata.
  always_comb begin
    state_d    = state_q;
    data_d     = data_q;
    rem_d      = rem_q;
    last_d     = last_q;
    o_tvalid_d = o_tvalid_q;
    o_tdata_d  = o_tdata_q;
    o_tlast_d  = o_tlast_q;
    load       = 1'b0;
    pop        = 1'b0;
    discard    = 1'b0;
    lane       = 2'd0;

    unique case (state_q)
      IDLE: begin
        if (fifo_level != '0) load = 1'b1;
      end
      SHIFT: begin
        if (byte_acc) begin
          if (rem_q != KEEP_NONE) begin
            lane      = next_lane(rem_q, 2'd0);
            o_tdata_d = lane_byte(data_q, lane);
            rem_d     = rem_q & ~(KEEP_W'(1) << lane);
            o_tlast_d = last_q && (rem_d == KEEP_NONE);
          end else if (fifo_level != '0) begin
            load = 1'b1;
          end else begin
            state_d    = IDLE;
            o_tvalid_d = 1'b0;
            o_tlast_d  = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (load) begin
      pop = 1'b1;
      if (head.keep == KEEP_NONE) begin
        discard    = 1'b1;
        state_d    = IDLE;
        o_tvalid_d = 1'b0;
        o_tlast_d  = 1'b0;
      end else begin
        lane       = next_lane(head.keep, 2'd0);
        data_d     = head.data;
        last_d     = head.last;
        rem_d      = head.keep & ~(KEEP_W'(1) << lane);
        o_tdata_d  = lane_byte(head.data, lane);
        o_tlast_d  = head.last && (rem_d == KEEP_NONE);
        o_tvalid_d = 1'b1;
        state_d    = SHIFT;
      end
    end

    lvl_nxt    = fifo_level + LVL_W'(push) - LVL_W'(pop);
    i_tready_d = (lvl_nxt < LVL_W'(DEPTH));
    busy_d     = (lvl_nxt != '0) || (state_d == SHIFT);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q    <= IDLE;
      data_q     <= '0;
      rem_q      <= KEEP_NONE;
      last_q     <= 1'b0;
      o_tvalid_q <= 1'b0;
      o_tdata_q  <= '0;
      o_tlast_q  <= 1'b0;
      i_tready_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      data_q     <= data_d;
      rem_q      <= rem_d;
      last_q     <= last_d;
      o_tvalid_q <= o_tvalid_d;
      o_tdata_q  <= o_tdata_d;
      o_tlast_q  <= o_tlast_d;
      i_tready_q <= i_tready_d;
      busy_q     <= busy_d;
    end
  end

  assign i_tready = i_tready_q;
  assign o_tvalid = o_tvalid_q;
  assign o_tdata  = o_tdata_q;
  assign o_tlast  = o_tlast_q;
  assign level    = fifo_level;
  assign busy     = busy_q;

`ifdef AXIS_SER_STATS_EN
  logic [15:0] pkt_cnt_q;
  logic [31:0] byte_cnt_q;
  logic [7:0]  null_cnt_q;

  // Counters wrap naturally at their width.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      pkt_cnt_q  <= '0;
      byte_cnt_q <= '0;
      null_cnt_q <= '0;
    end else begin
      if (byte_acc && o_tlast_q) pkt_cnt_q <= pkt_cnt_q + 16'd1;
      if (byte_acc)              byte_cnt_q <= byte_cnt_q + 32'd1;
      if (discard)               null_cnt_q <= null_cnt_q + 8'd1;
    end
  end

  assign pkt_count  = pkt_cnt_q;
  assign byte_count = byte_cnt_q;
  assign null_count = null_cnt_q;
`endif

endmodule

// File: tb/tb_axis_byte_serializer.sv
// Scoreboard bench for axis_byte_serializer: directed words, expected bytes queued, monitor compares.
module tb_axis_byte_serializer;

  localparam int unsigned DEPTH = 4;

  logic        clk;
  logic        rstn;
  logic        i_tvalid;
  logic        i_tready;
  logic [31:0] i_tdata;
  logic [3:0]  i_tkeep;
  logic        i_tlast;
  logic        o_tvalid;
  logic        o_tready;
  logic [7:0]  o_tdata;
  logic        o_tlast;
  logic [$clog2(DEPTH):0] level;
  logic        busy;
`ifdef AXIS_SER_STATS_EN
  logic [15:0] pkt_count;
  logic [31:0] byte_count;
  logic [7:0]  null_count;
`endif

  axis_byte_serializer #(
    .DEPTH (DEPTH)
  ) dut (
    .clk      (clk),
    .rstn     (rstn),
    .i_tvalid (i_tvalid),
    .i_tready (i_tready),
    .i_tdata  (i_tdata),
    .i_tkeep  (i_tkeep),
    .i_tlast  (i_tlast),
    .o_tvalid (o_tvalid),
    .o_tready (o_tready),
    .o_tdata  (o_tdata),
    .o_tlast  (o_tlast),
    .level    (level),
    .busy     (busy)
`ifdef AXIS_SER_STATS_EN
    ,
    .pkt_count  (pkt_count),
    .byte_count (byte_count),
    .null_count (null_count)
`endif
  );

  typedef struct {
    logic [7:0] data;
    logic       last;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   first_out_cyc = -1;
  int   last_out_cyc = -1;

  logic       stall_q = 1'b0;
  logic [7:0] stall_data = 8'h00;
  logic       stall_last = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: pops the scoreboard on every output handshake and checks hold-while-stalled.
  always @(negedge clk) begin
    exp_t e;
    if (!rstn) begin
      stall_q = 1'b0;
    end else begin
      if (stall_q) begin
        checks++;
        if (!(o_tvalid === 1'b1 && o_tdata === stall_data && o_tlast === stall_last)) begin
          failures++;
          $display("FAIL hold_stable actual=%b/%0h/%b required=1/%0h/%b",
                   o_tvalid, o_tdata, o_tlast, stall_data, stall_last);
        end
      end
      if (o_tvalid && o_tready) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_byte actual=%0h/%b required=none", o_tdata, o_tlast);
        end else begin
          e = exp_q.pop_front();
          if (o_tdata !== e.data || o_tlast !== e.last) begin
            failures++;
            $display("FAIL out_byte actual=%0h/%b required=%0h/%b", o_tdata, o_tlast, e.data, e.last);
          end
        end
        if (first_out_cyc < 0) first_out_cyc = cyc;
        last_out_cyc = cyc;
      end
      stall_q    = o_tvalid && !o_tready;
      stall_data = o_tdata;
      stall_last = o_tlast;
    end
  end

  task automatic expect_byte(input logic [7:0] d, input logic l);
    exp_t e;
    e.data = d;
    e.last = l;
    exp_q.push_back(e);
  endtask

  // Called just after a posedge; returns just after the accepting posedge with i_tvalid still high.
  task automatic send_word(input logic [31:0] d, input logic [3:0] k, input logic l, output int acc_cyc);
    bit ok;
    ok       = 1'b0;
    acc_cyc  = -1;
    i_tvalid = 1'b1;
    i_tdata  = d;
    i_tkeep  = k;
    i_tlast  = l;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      if (i_tready) begin
        ok      = 1'b1;
        acc_cyc = cyc;
      end
      @(posedge clk);
      #1;
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL send_timeout actual=not_accepted required=accepted data=%0h", d);
    end
  endtask

  task automatic idle_in();
    i_tvalid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 500 && !done; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !o_tvalid && !busy) done = 1'b1;
    end
    check({name, "_drained"}, {31'd0, done}, 32'd1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int acc;
    int acc0;
`ifdef AXIS_SER_STATS_EN
    logic [7:0] null_before;
`endif
    rstn     = 1'b0;
    i_tvalid = 1'b0;
    i_tdata  = 32'h0;
    i_tkeep  = 4'h0;
    i_tlast  = 1'b0;
    o_tready = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_o_tvalid", {31'd0, o_tvalid}, 32'd0);
    check("rst_o_tlast",  {31'd0, o_tlast}, 32'd0);
    check("rst_o_tdata",  {24'd0, o_tdata}, 32'd0);
    check("rst_level",    32'(level), 32'd0);
    check("rst_busy",     {31'd0, busy}, 32'd0);
    check("rst_i_tready", {31'd0, i_tready}, 32'd0);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("tready_after_rst", {31'd0, i_tready}, 32'd1);
    @(posedge clk);
    #1;

    // Single full word: latency and consecutive bytes
    o_tready = 1'b1;
    first_out_cyc = -1;
    expect_byte(8'h11, 1'b0);
    expect_byte(8'h22, 1'b0);
    expect_byte(8'h33, 1'b0);
    expect_byte(8'h44, 1'b1);
    send_word(32'h44332211, 4'b1111, 1'b1, acc);
    idle_in();
    wait_drain("single");
    check("single_latency", 32'(first_out_cyc - acc), 32'd2);
    check("single_span",    32'(last_out_cyc - first_out_cyc), 32'd3);

    // Two back-to-back words, no bubble
    first_out_cyc = -1;
    expect_byte(8'hA0, 1'b0);
    expect_byte(8'hA1, 1'b0);
    expect_byte(8'hA2, 1'b0);
    expect_byte(8'hA3, 1'b0);
    expect_byte(8'hB0, 1'b0);
    expect_byte(8'hB1, 1'b1);
    send_word(32'hA3A2A1A0, 4'b1111, 1'b0, acc0);
    send_word(32'hFFFFB1B0, 4'b0011, 1'b1, acc);
    idle_in();
    wait_drain("b2b");
    check("b2b_span", 32'(last_out_cyc - first_out_cyc), 32'd5);

    // Sparse and single-lane keeps
    expect_byte(8'hAA, 1'b0);
    expect_byte(8'hCC, 1'b1);
    send_word(32'hDDCCBBAA, 4'b0101, 1'b1, acc);
    expect_byte(8'h33, 1'b0);
    expect_byte(8'h22, 1'b0);
    send_word(32'h11223344, 4'b0110, 1'b0, acc);
    expect_byte(8'hAB, 1'b1);
    send_word(32'hAB000000, 4'b1000, 1'b1, acc);
    idle_in();
    wait_drain("sparse");

    // Null word between two packets
`ifdef AXIS_SER_STATS_EN
    null_before = null_count;
`endif
    expect_byte(8'hEF, 1'b0);
    expect_byte(8'hBE, 1'b1);
    send_word(32'h0000BEEF, 4'b0011, 1'b1, acc);
    send_word(32'h12345678, 4'b0000, 1'b1, acc);
    expect_byte(8'h5A, 1'b1);
    send_word(32'h0000005A, 4'b0001, 1'b1, acc);
    idle_in();
    wait_drain("null");
`ifdef AXIS_SER_STATS_EN
    check("null_count", {24'd0, null_count}, {24'd0, null_before + 8'd1});
`endif

    // Backpressure: five words, 20 bytes, FIFO fills to DEPTH
    o_tready = 1'b0;
    first_out_cyc = -1;
    for (int k = 0; k < 20; k++) expect_byte(8'(k), k == 19);
    for (int w = 0; w < 5; w++) begin
      send_word(32'h03020100 + 32'(w) * 32'h04040404, 4'b1111, w == 4, acc);
    end
    idle_in();
    repeat (14) @(posedge clk);
    @(negedge clk);
    check("bp_level",    32'(level), 32'd4);
    check("bp_i_tready", {31'd0, i_tready}, 32'd0);
    check("bp_busy",     {31'd0, busy}, 32'd1);
    check("bp_head",     {23'd0, o_tvalid, o_tdata}, {23'd0, 1'b1, 8'h00});
    @(posedge clk);
    #1;
    o_tready = 1'b1;
    wait_drain("bp");
    check("bp_span", 32'(last_out_cyc - first_out_cyc), 32'd19);

    // Toggling o_tready while streaming
    expect_byte(8'h55, 1'b0);
    expect_byte(8'h66, 1'b0);
    expect_byte(8'h77, 1'b0);
    expect_byte(8'h88, 1'b0);
    expect_byte(8'h99, 1'b1);
    fork
      begin
        int a;
        send_word(32'h88776655, 4'b1111, 1'b0, a);
        send_word(32'h00000099, 4'b0001, 1'b1, a);
        idle_in();
      end
      begin
        for (int t = 0; t < 16; t++) begin
          o_tready = ~o_tready;
          @(posedge clk);
          #1;
        end
        o_tready = 1'b1;
      end
    join
    wait_drain("toggle");

    // Reset after the second byte of a word
    expect_byte(8'h11, 1'b0);
    expect_byte(8'h22, 1'b0);
    expect_byte(8'h33, 1'b0);
    expect_byte(8'h44, 1'b1);
    send_word(32'h44332211, 4'b1111, 1'b1, acc);
    idle_in();
    for (int i = 0; i < 50; i++) begin
      if (exp_q.size() <= 2) break;
      @(posedge clk);
      #1;
    end
    rstn = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("mid_rst_o_tvalid", {31'd0, o_tvalid}, 32'd0);
    check("mid_rst_level",    32'(level), 32'd0);
    check("mid_rst_pending",  32'(exp_q.size()), 32'd2);
    exp_q.delete();
    @(posedge clk);
    #1;
    rstn = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("post_rst_quiet", {31'd0, o_tvalid}, 32'd0);
    expect_byte(8'h77, 1'b1);
    send_word(32'h00000077, 4'b0001, 1'b1, acc);
    idle_in();
    wait_drain("post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
